// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and helpers for the neural_network blocks
package nn_pkg;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_RELU,
    ACT_SIGMOID,
    ACT_TANH
  } activation_type;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    STREAM
  } reader_state_t;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int index_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_result_reader.sv
// rtl/nn_result_reader.sv - captures a network result vector, finds its signed argmax, streams it out
module nn_result_reader
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUTPUTS = 2,
  localparam int INDEX_WIDTH = index_width(NUM_OUTPUTS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         outputs_ready,
  input  logic signed [DATA_WIDTH-1:0] outputs [NUM_OUTPUTS],
  output logic signed [DATA_WIDTH-1:0] result_data,
  output logic [INDEX_WIDTH-1:0]       result_index,
  output logic                         result_valid,
  output logic                         result_last,
  input  logic                         result_ready,
  output logic [INDEX_WIDTH-1:0]       class_index,
  output logic                         class_valid,
  output logic                         busy,
  output logic                         overflow
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_OUTPUTS - 1);

  reader_state_t state, state_next;

  logic signed [DATA_WIDTH-1:0] capture [NUM_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] best;
  logic [INDEX_WIDTH-1:0]       idx;
  logic [INDEX_WIDTH-1:0]       best_index;

  logic last_element;
  logic in_stream;
  logic last_beat;
  logic accept;
  logic better;

  assign last_element = (idx == LAST_INDEX);
  assign in_stream    = (state == STREAM);
  assign last_beat    = in_stream && result_ready && last_element;
  // A new vector is taken from IDLE, or in the very cycle the final beat leaves.
  assign accept       = outputs_ready && ((state == IDLE) || last_beat);
  assign better       = capture[idx] > best;

  assign result_valid = in_stream;
  assign result_last  = in_stream && last_element;
  assign result_data  = in_stream ? capture[idx] : '0;
  assign result_index = in_stream ? idx : '0;
  assign busy         = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (outputs_ready) state_next = SCAN;
      SCAN:    if (last_element) state_next = STREAM;
      STREAM:  if (last_beat) state_next = outputs_ready ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) capture[i] <= '0;
      best        <= '0;
      best_index  <= '0;
      idx         <= '0;
      class_index <= '0;
      class_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      if (outputs_ready && !accept) overflow <= 1'b1;
      if (accept) begin
        capture    <= outputs;
        best       <= outputs[0];
        best_index <= '0;
        idx        <= '0;
      end else if (state == SCAN) begin
        if (better) begin
          best       <= capture[idx];
          best_index <= idx;
        end
        if (last_element) begin
          // The final compare resolves this cycle, so select its winner directly.
          class_index <= better ? idx : best_index;
          class_valid <= 1'b1;
          idx         <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (in_stream && result_ready && !last_element) begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nn_result_reader.sv
// tb/tb_nn_result_reader.sv - directed self-checking bench for nn_result_reader
module tb_nn_result_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               outputs_ready;
  logic signed [31:0] vec4 [4];
  logic signed [31:0] result_data;
  logic [1:0]         result_index;
  logic               result_valid;
  logic               result_last;
  logic               result_ready;
  logic [1:0]         class_index;
  logic               class_valid;
  logic               busy;
  logic               overflow;

  logic               outputs_ready1;
  logic signed [31:0] vec1 [1];
  logic signed [31:0] result_data1;
  logic [0:0]         result_index1;
  logic               result_valid1;
  logic               result_last1;
  logic               result_ready1;
  logic [0:0]         class_index1;
  logic               class_valid1;
  logic               busy1;
  logic               overflow1;

  int compared = 0;
  int mismatched = 0;

  nn_result_reader #(.DATA_WIDTH(32), .NUM_OUTPUTS(4)) dut4 (
    .clock(clk), .reset(rst), .outputs_ready(outputs_ready), .outputs(vec4),
    .result_data(result_data), .result_index(result_index), .result_valid(result_valid),
    .result_last(result_last), .result_ready(result_ready), .class_index(class_index),
    .class_valid(class_valid), .busy(busy), .overflow(overflow)
  );

  nn_result_reader #(.DATA_WIDTH(32), .NUM_OUTPUTS(1)) dut1 (
    .clock(clk), .reset(rst), .outputs_ready(outputs_ready1), .outputs(vec1),
    .result_data(result_data1), .result_index(result_index1), .result_valid(result_valid1),
    .result_last(result_last1), .result_ready(result_ready1), .class_index(class_index1),
    .class_valid(class_valid1), .busy(busy1), .overflow(overflow1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int a, input int b, input int c, input int d);
    vec4[0] = a; vec4[1] = b; vec4[2] = c; vec4[3] = d;
  endtask

  // Drive outputs_ready for one cycle; returns in cycle 1 of the transaction.
  task automatic pulse();
    outputs_ready = 1'b1;
    step();
    outputs_ready = 1'b0;
  endtask

  // Called in the first STREAM cycle with result_ready high.
  task automatic drain(input string tag, input int a, input int b, input int c, input int d);
    int e [4];
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_data%0d", tag, i), result_data, e[i]);
      check($sformatf("%s_index%0d", tag, i), 32'(result_index), i);
      check($sformatf("%s_valid%0d", tag, i), 32'(result_valid), 1);
      check($sformatf("%s_last%0d", tag, i), 32'(result_last), 32'(i == 3));
      if (i == 1) check($sformatf("%s_cv_one_cycle", tag), 32'(class_valid), 0);
      step();
    end
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_valid_end"}, 32'(result_valid), 0);
  endtask

  task automatic run_vec(input string tag, input int a, input int b, input int c, input int d,
                         input int cls);
    set_vec(a, b, c, d);
    pulse();
    check({tag, "_busy_c1"}, 32'(busy), 1);
    check({tag, "_cv_c1"}, 32'(class_valid), 0);
    repeat (3) step();
    check({tag, "_valid_c4"}, 32'(result_valid), 0);
    step();
    check({tag, "_cv_c5"}, 32'(class_valid), 1);
    check({tag, "_class"}, 32'(class_index), cls);
    drain(tag, a, b, c, d);
  endtask

  initial begin
    int beats;
    rst = 1'b1;
    outputs_ready = 1'b0;
    result_ready = 1'b1;
    set_vec(0, 0, 0, 0);
    outputs_ready1 = 1'b0;
    result_ready1 = 1'b1;
    vec1[0] = 0;
    repeat (2) step();

    check("rst_valid", 32'(result_valid), 0);
    check("rst_data", result_data, 0);
    check("rst_index", 32'(result_index), 0);
    check("rst_last", 32'(result_last), 0);
    check("rst_class", 32'(class_index), 0);
    check("rst_cv", 32'(class_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    step();

    run_vec("basic", 5, -3, 12, 7, 2);
    run_vec("tie", -10, -2, -2, -100, 1);
    run_vec("neg", -8, -9, -7, -7, 2);

    // Backpressure: ready low in cycles 5-9, then alternating.
    result_ready = 1'b0;
    set_vec(1, 2, 3, 4);
    pulse();
    repeat (4) step();
    beats = 0;
    for (int c = 5; c < 20; c++) begin
      result_ready = (c >= 10) && (c % 2 == 0);
      if (result_valid && beats < 4) begin
        check($sformatf("bp_data_c%0d", c), result_data, beats + 1);
        check($sformatf("bp_index_c%0d", c), 32'(result_index), beats);
        if (result_ready) beats++;
      end
      step();
    end
    check("bp_beats", beats, 4);
    check("bp_busy_end", 32'(busy), 0);
    result_ready = 1'b1;

    // Overflow during SCAN, then a vector coincident with the last beat.
    set_vec(3, 1, 4, 1);
    pulse();
    step();
    check("ovf_before", 32'(overflow), 0);
    set_vec(100, 100, 100, 100);
    pulse();
    check("ovf_set", 32'(overflow), 1);
    check("ovf_busy", 32'(busy), 1);
    repeat (2) step();
    check("ovf_cv", 32'(class_valid), 1);
    check("ovf_class", 32'(class_index), 2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ovf_data%0d", i), result_data, (i == 0) ? 3 : (i == 1) ? 1 : 4);
      step();
    end
    check("ovf_data3", result_data, 1);
    check("ovf_last3", 32'(result_last), 1);
    set_vec(2, 8, 8, -1);
    pulse();
    check("b2b_busy", 32'(busy), 1);
    check("b2b_valid", 32'(result_valid), 0);
    check("b2b_ovf", 32'(overflow), 1);
    repeat (4) step();
    check("b2b_cv", 32'(class_valid), 1);
    check("b2b_class", 32'(class_index), 1);
    drain("b2b", 2, 8, 8, -1);

    // Asynchronous reset mid-STREAM after beat 1 has transferred.
    set_vec(6, 7, 8, 9);
    pulse();
    repeat (4) step();
    check("mid_class", 32'(class_index), 3);
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(result_valid), 0);
    check("arst_data", result_data, 0);
    check("arst_index", 32'(result_index), 0);
    check("arst_class", 32'(class_index), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ovf", 32'(overflow), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("post_rst_valid", 32'(result_valid), 0);
    run_vec("post_rst", 0, 0, 9, 0, 2);

    // Single-output instance.
    vec1[0] = -42;
    outputs_ready1 = 1'b1;
    step();
    outputs_ready1 = 1'b0;
    check("n1_busy_c1", 32'(busy1), 1);
    check("n1_cv_c1", 32'(class_valid1), 0);
    step();
    check("n1_cv_c2", 32'(class_valid1), 1);
    check("n1_class", 32'(class_index1), 0);
    check("n1_valid", 32'(result_valid1), 1);
    check("n1_data", result_data1, -42);
    check("n1_last", 32'(result_last1), 1);
    check("n1_index", 32'(result_index1), 0);
    step();
    check("n1_busy_end", 32'(busy1), 0);
    check("n1_valid_end", 32'(result_valid1), 0);
    check("n1_ovf", 32'(overflow1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
